// File: rtl/kbd_scancode_decoder.sv
// PS/2 scan-code decoder: pops bytes from the ps2_keyboard FIFO, tracks
// break/extended prefixes and modifier keys, and reports the last
// non-modifier key press with its ASCII value and a running press count.
//
// state | meaning
// IDLE  | waiting for ready; the head byte is decoded on the accepting edge
// POP   | nextdata_n held low for one cycle to pop the consumed byte
// GAP   | one settle cycle so ready reflects the popped FIFO
module kbd_scancode_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic             key_valid,
  output logic             key_down,
  output logic             extended,
  output logic [CNT_W-1:0] press_count,
  output logic             shift,
  output logic             ctrl,
  output logic             caps,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_nextdata_n;
  logic [7:0]       r_key_code;
  logic [7:0]       r_key_ascii;
  logic             r_key_valid;
  logic             r_key_down;
  logic             r_extended;
  logic [CNT_W-1:0] r_press_count;
  logic             r_shift;
  logic             r_ctrl;
  logic             r_caps;
  logic             r_caps_held;
  logic             r_err;
  logic             r_ext_pending;
  logic             r_brk_pending;

  logic       w_is_shift;
  logic       w_is_ctrl;
  logic       w_is_caps;
  logic       w_is_mod;
  logic       w_same_key;
  logic [7:0] w_ascii;

  // Set 2 make code to ASCII; extended keys have no ASCII value.
  function automatic logic [7:0] f_ascii(input logic [7:0] code,
                                         input logic       ext,
                                         input logic       upper);
    logic [7:0] v;
    logic       letter;
    v      = 8'h00;
    letter = 1'b0;
    case (code)
      8'h1C: begin v = 8'h61; letter = 1'b1; end
      8'h32: begin v = 8'h62; letter = 1'b1; end
      8'h21: begin v = 8'h63; letter = 1'b1; end
      8'h23: begin v = 8'h64; letter = 1'b1; end
      8'h24: begin v = 8'h65; letter = 1'b1; end
      8'h2B: begin v = 8'h66; letter = 1'b1; end
      8'h34: begin v = 8'h67; letter = 1'b1; end
      8'h33: begin v = 8'h68; letter = 1'b1; end
      8'h43: begin v = 8'h69; letter = 1'b1; end
      8'h3B: begin v = 8'h6A; letter = 1'b1; end
      8'h42: begin v = 8'h6B; letter = 1'b1; end
      8'h4B: begin v = 8'h6C; letter = 1'b1; end
      8'h3A: begin v = 8'h6D; letter = 1'b1; end
      8'h31: begin v = 8'h6E; letter = 1'b1; end
      8'h44: begin v = 8'h6F; letter = 1'b1; end
      8'h4D: begin v = 8'h70; letter = 1'b1; end
      8'h15: begin v = 8'h71; letter = 1'b1; end
      8'h2D: begin v = 8'h72; letter = 1'b1; end
      8'h1B: begin v = 8'h73; letter = 1'b1; end
      8'h2C: begin v = 8'h74; letter = 1'b1; end
      8'h3C: begin v = 8'h75; letter = 1'b1; end
      8'h2A: begin v = 8'h76; letter = 1'b1; end
      8'h1D: begin v = 8'h77; letter = 1'b1; end
      8'h22: begin v = 8'h78; letter = 1'b1; end
      8'h35: begin v = 8'h79; letter = 1'b1; end
      8'h1A: begin v = 8'h7A; letter = 1'b1; end
      8'h45: v = 8'h30;
      8'h16: v = 8'h31;
      8'h1E: v = 8'h32;
      8'h26: v = 8'h33;
      8'h25: v = 8'h34;
      8'h2E: v = 8'h35;
      8'h36: v = 8'h36;
      8'h3D: v = 8'h37;
      8'h3E: v = 8'h38;
      8'h46: v = 8'h39;
      8'h29: v = 8'h20;
      8'h5A: v = 8'h0D;
      8'h66: v = 8'h08;
      default: v = 8'h00;
    endcase
    if (letter && upper) v = v - 8'h20;
    if (ext) v = 8'h00;
    return v;
  endfunction

  assign w_is_shift = (data == 8'h12) || (data == 8'h59);
  assign w_is_ctrl  = (data == 8'h14);
  assign w_is_caps  = (data == 8'h58);
  assign w_is_mod   = w_is_shift || w_is_ctrl || w_is_caps;
  assign w_same_key = r_key_down && (data == r_key_code) && (r_ext_pending == r_extended);
  assign w_ascii    = f_ascii(data, r_ext_pending, r_shift ^ r_caps);

  // Pop-handshake FSM and scan-code decode; all outputs registered.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state       <= S_IDLE;
      r_nextdata_n  <= 1'b1;
      r_key_code    <= 8'h00;
      r_key_ascii   <= 8'h00;
      r_key_valid   <= 1'b0;
      r_key_down    <= 1'b0;
      r_extended    <= 1'b0;
      r_press_count <= '0;
      r_shift       <= 1'b0;
      r_ctrl        <= 1'b0;
      r_caps        <= 1'b0;
      r_caps_held   <= 1'b0;
      r_err         <= 1'b0;
      r_ext_pending <= 1'b0;
      r_brk_pending <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (overflow) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (ready) begin
            r_state      <= S_POP;
            r_nextdata_n <= 1'b0;
            if (data == 8'hE0) begin
              r_ext_pending <= 1'b1;
            end else if (data == 8'hF0) begin
              r_brk_pending <= 1'b1;
            end else if (r_brk_pending) begin
              if (w_is_shift) r_shift <= 1'b0;
              if (w_is_ctrl) r_ctrl <= 1'b0;
              if (w_is_caps) r_caps_held <= 1'b0;
              if ((data == r_key_code) && (r_ext_pending == r_extended)) r_key_down <= 1'b0;
              r_brk_pending <= 1'b0;
              r_ext_pending <= 1'b0;
            end else begin
              r_ext_pending <= 1'b0;
              if (w_is_shift) r_shift <= 1'b1;
              if (w_is_ctrl) r_ctrl <= 1'b1;
              if (w_is_caps) begin
                // Typematic repeats of a held caps key must not re-toggle.
                if (!r_caps_held) r_caps <= ~r_caps;
                r_caps_held <= 1'b1;
              end
              if (!w_is_mod && !w_same_key) begin
                r_key_code    <= data;
                r_key_ascii   <= w_ascii;
                r_extended    <= r_ext_pending;
                r_key_down    <= 1'b1;
                r_press_count <= r_press_count + CNT_W'(1);
                r_key_valid   <= 1'b1;
              end
            end
          end
        end
        S_POP: begin
          r_state      <= S_GAP;
          r_nextdata_n <= 1'b1;
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state      <= S_IDLE;
          r_nextdata_n <= 1'b1;
        end
      endcase
    end
  end

  assign nextdata_n  = r_nextdata_n;
  assign key_code    = r_key_code;
  assign key_ascii   = r_key_ascii;
  assign key_valid   = r_key_valid;
  assign key_down    = r_key_down;
  assign extended    = r_extended;
  assign press_count = r_press_count;
  assign shift       = r_shift;
  assign ctrl        = r_ctrl;
  assign caps        = r_caps;
  assign err         = r_err;

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// Bench for kbd_scancode_decoder: table of key mappings, hand-written
// multi-byte sequences and a random byte stream checked against a
// behavioural keyboard model.
module tb_kbd_scancode_decoder;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;
  logic       overflow = 1'b0;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic [7:0] key_ascii;
  logic       key_valid;
  logic       key_down;
  logic       extended;
  logic [7:0] press_count;
  logic       shift;
  logic       ctrl;
  logic       caps;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid_seen = 0;

  kbd_scancode_decoder #(.CNT_W(8)) dut (
    .clk(clk), .clr(clr), .data(data), .ready(ready), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_code(key_code), .key_ascii(key_ascii),
    .key_valid(key_valid), .key_down(key_down), .extended(extended),
    .press_count(press_count), .shift(shift), .ctrl(ctrl), .caps(caps), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] LETTERS [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] POOL [18] = '{
    8'hE0, 8'hF0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h58, 8'h1C, 8'h1B,
    8'h32, 8'h45, 8'h29, 8'h5A, 8'h66, 8'h75, 8'h0E, 8'h1C, 8'h1B};

  // keyboard model state
  logic [7:0] m_code, m_ascii, m_cnt;
  logic m_down, m_ext, m_shift, m_ctrl, m_caps, m_caps_held, m_err;
  logic m_extp, m_brkp, m_valid;

  function automatic logic [7:0] ref_ascii(input logic [7:0] b, input logic e, input logic up);
    if (e) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (LETTERS[i] == b) return (up ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (DIGITS[i] == b) return 8'h30 + 8'(i);
    if (b == 8'h29) return 8'h20;
    if (b == 8'h5A) return 8'h0D;
    if (b == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_code = 0; m_ascii = 0; m_cnt = 0; m_down = 0; m_ext = 0;
    m_shift = 0; m_ctrl = 0; m_caps = 0; m_caps_held = 0; m_err = 0;
    m_extp = 0; m_brkp = 0; m_valid = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic is_mod;
    m_valid = 0;
    is_mod = (b == 8'h12) || (b == 8'h59) || (b == 8'h14) || (b == 8'h58);
    if (b == 8'hE0) m_extp = 1;
    else if (b == 8'hF0) m_brkp = 1;
    else if (m_brkp) begin
      if (b == 8'h12 || b == 8'h59) m_shift = 0;
      if (b == 8'h14) m_ctrl = 0;
      if (b == 8'h58) m_caps_held = 0;
      if (b == m_code && m_extp == m_ext) m_down = 0;
      m_brkp = 0;
      m_extp = 0;
    end else begin
      if (b == 8'h12 || b == 8'h59) m_shift = 1;
      if (b == 8'h14) m_ctrl = 1;
      if (b == 8'h58) begin
        if (!m_caps_held) m_caps = ~m_caps;
        m_caps_held = 1;
      end
      if (!is_mod && !(m_down && b == m_code && m_extp == m_ext)) begin
        m_ascii = ref_ascii(b, m_extp, m_shift ^ m_caps);
        m_code = b;
        m_ext = m_extp;
        m_down = 1;
        m_cnt = m_cnt + 8'd1;
        m_valid = 1;
      end
      m_extp = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".key_code"}, 32'(key_code), 32'(m_code));
    check({tag, ".key_ascii"}, 32'(key_ascii), 32'(m_ascii));
    check({tag, ".key_down"}, 32'(key_down), 32'(m_down));
    check({tag, ".extended"}, 32'(extended), 32'(m_ext));
    check({tag, ".press_count"}, 32'(press_count), 32'(m_cnt));
    check({tag, ".shift"}, 32'(shift), 32'(m_shift));
    check({tag, ".ctrl"}, 32'(ctrl), 32'(m_ctrl));
    check({tag, ".caps"}, 32'(caps), 32'(m_caps));
    check({tag, ".err"}, 32'(err), 32'(m_err));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data = b;
    ready = 1;
    @(posedge clk);
    #1;
    ready = 0;
    data = 8'h00;
    model_byte(b);
    check("pop_low", 32'(nextdata_n), 32'd0);
    check("valid_pulse", 32'(key_valid), 32'(m_valid));
    if (key_valid) n_valid_seen++;
    @(posedge clk);
    #1;
    check("gap_high", 32'(nextdata_n), 32'd1);
    check("valid_one_cycle", 32'(key_valid), 32'd0);
    @(posedge clk);
    #1;
    check("idle_high", 32'(nextdata_n), 32'd1);
    check_all("byte");
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
    model_reset();
    check("reset.nextdata_n", 32'(nextdata_n), 32'd1);
    check("reset.key_valid", 32'(key_valid), 32'd0);
    check_all("reset");
  endtask

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       shf;
    logic [7:0] exp_ascii;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int pops;
    int v0;
    logic [7:0] b;

    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 8'h61};
    vecs[1]  = '{8'h1C, 1'b0, 1'b1, 8'h41};
    vecs[2]  = '{8'h1A, 1'b0, 1'b0, 8'h7A};
    vecs[3]  = '{8'h15, 1'b0, 1'b1, 8'h51};
    vecs[4]  = '{8'h4D, 1'b0, 1'b0, 8'h70};
    vecs[5]  = '{8'h45, 1'b0, 1'b0, 8'h30};
    vecs[6]  = '{8'h45, 1'b0, 1'b1, 8'h30};
    vecs[7]  = '{8'h46, 1'b0, 1'b0, 8'h39};
    vecs[8]  = '{8'h29, 1'b0, 1'b0, 8'h20};
    vecs[9]  = '{8'h5A, 1'b0, 1'b0, 8'h0D};
    vecs[10] = '{8'h66, 1'b0, 1'b0, 8'h08};
    vecs[11] = '{8'h0E, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{8'h75, 1'b1, 1'b0, 8'h00};
    vecs[13] = '{8'h1C, 1'b1, 1'b0, 8'h00};

    model_reset();
    repeat (2) @(posedge clk);
    do_clr();

    // mapping table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].shf) send_byte(8'h12);
      if (vecs[i].ext) send_byte(8'hE0);
      send_byte(vecs[i].code);
      check("vec_ascii", 32'(key_ascii), 32'(vecs[i].exp_ascii));
      check("vec_code", 32'(key_code), 32'(vecs[i].code));
      check("vec_ext", 32'(extended), 32'(vecs[i].ext));
      check("vec_down", 32'(key_down), 32'd1);
      if (vecs[i].ext) send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(vecs[i].code);
      check("vec_released", 32'(key_down), 32'd0);
      if (vecs[i].shf) begin
        send_byte(8'hF0);
        send_byte(8'h12);
      end
    end

    // single press / release
    do_clr();
    v0 = n_valid_seen;
    send_byte(8'h1C);
    check("press.code", 32'(key_code), 32'h1C);
    check("press.ascii", 32'(key_ascii), 32'h61);
    check("press.count", 32'(press_count), 32'd1);
    check("press.down", 32'(key_down), 32'd1);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("release.down", 32'(key_down), 32'd0);
    check("release.count", 32'(press_count), 32'd1);
    check("press.valid_pulses", 32'(n_valid_seen - v0), 32'd1);

    // typematic repeat
    v0 = n_valid_seen;
    send_byte(8'h1B);
    send_byte(8'h1B);
    send_byte(8'h1B);
    check("repeat.valid_pulses", 32'(n_valid_seen - v0), 32'd1);
    check("repeat.count", 32'(press_count), 32'd2);
    check("repeat.ascii", 32'(key_ascii), 32'h73);
    send_byte(8'hF0);
    send_byte(8'h1B);
    check("repeat.release", 32'(key_down), 32'd0);

    // shift and caps
    send_byte(8'h12);
    check("shift.set", 32'(shift), 32'd1);
    send_byte(8'h1C);
    check("shift.ascii", 32'(key_ascii), 32'h41);
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h12);
    check("shift.clear", 32'(shift), 32'd0);
    send_byte(8'h58);
    send_byte(8'hF0);
    send_byte(8'h58);
    check("caps.on", 32'(caps), 32'd1);
    send_byte(8'h1C);
    check("caps.ascii", 32'(key_ascii), 32'h41);
    send_byte(8'h59);
    check("caps_shift.not_retroactive", 32'(key_ascii), 32'h41);
    send_byte(8'hF0);
    send_byte(8'h59);
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'h58);
    send_byte(8'h58);
    check("caps.typematic", 32'(caps), 32'd0);
    send_byte(8'hF0);
    send_byte(8'h58);
    send_byte(8'h58);
    check("caps.retoggle", 32'(caps), 32'd1);
    send_byte(8'hF0);
    send_byte(8'h58);
    send_byte(8'h14);
    check("ctrl.set", 32'(ctrl), 32'd1);
    send_byte(8'hF0);
    send_byte(8'h14);
    check("ctrl.clear", 32'(ctrl), 32'd0);

    // extended key
    do_clr();
    send_byte(8'hE0);
    send_byte(8'h75);
    check("ext.flag", 32'(extended), 32'd1);
    check("ext.ascii", 32'(key_ascii), 32'h00);
    check("ext.count", 32'(press_count), 32'd1);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("ext.plain_release_keeps", 32'(key_down), 32'd1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("ext.release", 32'(key_down), 32'd0);

    // clr discards a pending break, issued during POP
    do_clr();
    @(negedge clk);
    data = 8'hF0;
    ready = 1;
    @(posedge clk);
    #1;
    ready = 0;
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
    model_reset();
    check("clr_in_pop.nextdata_n", 32'(nextdata_n), 32'd1);
    send_byte(8'h1C);
    check("clr_in_pop.make", 32'(key_down), 32'd1);
    check("clr_in_pop.count", 32'(press_count), 32'd1);

    // clr dominates an offered byte
    @(negedge clk);
    data = 8'h1B;
    ready = 1;
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
    ready = 0;
    model_reset();
    check("clr_dominates.nextdata_n", 32'(nextdata_n), 32'd1);
    check("clr_dominates.count", 32'(press_count), 32'd0);

    // ready held high: one byte per three cycles
    @(negedge clk);
    data = 8'h2C;
    ready = 1;
    pops = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (!nextdata_n) pops++;
    end
    ready = 0;
    model_byte(8'h2C);
    model_byte(8'h2C);
    check("held_ready.pops", 32'(pops), 32'd2);
    check_all("held_ready");
    send_byte(8'hF0);
    send_byte(8'h2C);

    // overflow makes err sticky until clr
    @(negedge clk);
    overflow = 1;
    @(posedge clk);
    #1;
    overflow = 0;
    m_err = 1;
    check("err.set", 32'(err), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("err.sticky", 32'(err), 32'd1);
    send_byte(8'h1C);
    do_clr();
    @(negedge clk);
    overflow = 1;
    clr = 1;
    @(posedge clk);
    #1;
    overflow = 0;
    clr = 0;
    check("err.clr_dominates", 32'(err), 32'd0);

    // press count wrap
    do_clr();
    for (int i = 0; i < 256; i++) begin
      send_byte(LETTERS[i % 26]);
      send_byte(8'hF0);
      send_byte(LETTERS[i % 26]);
      if (i == 254) check("wrap.count255", 32'(press_count), 32'd255);
    end
    check("wrap.count0", 32'(press_count), 32'd0);

    // random byte stream
    do_clr();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_clr();
      end else begin
        if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
        else b = POOL[$urandom_range(0, 17)];
        send_byte(b);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
